// File: rtl/piano_pkg.sv
`default_nettype none
// ==========================================================================
// piano_pkg : shared button indices, mode encodings and debounce default
// Rev 1.0
// ==========================================================================
package piano_pkg;

  localparam int BTN_PREV  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_NEXT  = 2;

  typedef enum logic [2:0] {
    MODE_MANUAL = 3'b001,
    MODE_AUTO   = 3'b011,
    MODE_STUDY  = 3'b111
  } mode_e;

  // 20 ms at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 2000000;

endpackage : piano_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ==========================================================================
// button_debounce : 2-flop synchroniser plus stable-count level debouncer
// Rev 1.0
// ==========================================================================
module button_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_sync,
  output logic btn_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_sync  = sync2_q;
  assign btn_level = level_q;

endmodule : button_debounce
`default_nettype wire

// File: rtl/song_selector.sv
`default_nettype none
// ==========================================================================
// song_selector : debounced prev/pause/next buttons -> song index and pause
// Rev 1.0
// ==========================================================================
module song_selector
  import piano_pkg::*;
#(
  parameter int NUM_SONGS       = 4,
  parameter int SONG_W          = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        button,
  input  logic              enable,
  output logic [SONG_W-1:0] song_num,
  output logic              paused,
  output logic              song_change,
  output logic [2:0]        btn_level
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic [2:0] btn_sync;
  logic [2:0] btn_lvl;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (button[i]),
        .btn_sync (btn_sync[i]),
        .btn_level(btn_lvl[i])
      );
    end
  endgenerate

  logic [SONG_W-1:0] song_num_q,    song_num_d;
  logic              paused_q,      paused_d;
  logic              song_change_q, song_change_d;
  logic [2:0]        level_prev_q,  level_prev_d;
  logic [2:0]        block_q,       block_d;
  logic [1:0]        warm_q,        warm_d;

  logic [2:0] press;
  logic [2:0] act;

  always_comb begin
    level_prev_d = btn_lvl;
    warm_d       = {warm_q[0], 1'b1};
    // A button held through reset stays blocked until the synchronised input
    // is seen low (with the synchroniser refilled) and the level is low.
    block_d      = block_q & ~({3{warm_q[1]}} & ~btn_sync & ~btn_lvl);

    press = btn_lvl & ~level_prev_q & ~block_q;
    act   = press & {3{enable}};

    song_num_d    = song_num_q;
    paused_d      = paused_q;
    song_change_d = 1'b0;

    if (act[BTN_PAUSE]) begin
      paused_d = ~paused_q;
    end
    if (act[BTN_NEXT] && !act[BTN_PREV]) begin
      song_num_d    = (song_num_q == LAST_SONG) ? '0 : song_num_q + SONG_W'(1);
      paused_d      = 1'b0;
      song_change_d = 1'b1;
    end else if (act[BTN_PREV] && !act[BTN_NEXT]) begin
      song_num_d    = (song_num_q == '0) ? LAST_SONG : song_num_q - SONG_W'(1);
      paused_d      = 1'b0;
      song_change_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      song_num_q    <= '0;
      paused_q      <= 1'b0;
      song_change_q <= 1'b0;
      level_prev_q  <= '0;
      block_q       <= 3'b111;
      warm_q        <= '0;
    end else begin
      song_num_q    <= song_num_d;
      paused_q      <= paused_d;
      song_change_q <= song_change_d;
      level_prev_q  <= level_prev_d;
      block_q       <= block_d;
      warm_q        <= warm_d;
    end
  end

  assign song_num    = song_num_q;
  assign paused      = paused_q;
  assign song_change = song_change_q;
  assign btn_level   = btn_lvl;

endmodule : song_selector
`default_nettype wire
